// File: rtl/dsa_host_arbiter.sv
// dsa_host_arbiter: two-requester round-robin arbiter in front of a single
// downstream host port. Writes are posted (one per cycle); a read holds the
// port in WAIT_RD until h_rvalid or a timeout, which answers with DEAD_BEEF.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   m0_*/m1_*                 requester ports (address/read/write/writedata in,
//                             waitrequest/readdata/readdatavalid out)
//   h_wr_en/h_rd_en/h_addr/h_wdata   registered host request
//   h_rdata/h_rvalid          host read return
//   grant, busy, err_cnt      status: last owner, WAIT_RD flag, timeout count
module dsa_host_arbiter #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned RD_TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic [ADDR_WIDTH-1:0] m0_address,
    input  logic                  m0_read,
    input  logic                  m0_write,
    input  logic [31:0]           m0_writedata,
    output logic                  m0_waitrequest,
    output logic [31:0]           m0_readdata,
    output logic                  m0_readdatavalid,

    input  logic [ADDR_WIDTH-1:0] m1_address,
    input  logic                  m1_read,
    input  logic                  m1_write,
    input  logic [31:0]           m1_writedata,
    output logic                  m1_waitrequest,
    output logic [31:0]           m1_readdata,
    output logic                  m1_readdatavalid,

    output logic                  h_wr_en,
    output logic                  h_rd_en,
    output logic [15:0]           h_addr,
    output logic [31:0]           h_wdata,
    input  logic [31:0]           h_rdata,
    input  logic                  h_rvalid,

    output logic [1:0]            grant,
    output logic                  busy,
    output logic [7:0]            err_cnt
);

    localparam int unsigned CNT_W   = 10;
    localparam logic [CNT_W-1:0] TMO_LIMIT = CNT_W'(RD_TIMEOUT);
    localparam logic [31:0] TMO_DATA = 32'hDEAD_BEEF;

    typedef enum logic {
        IDLE    = 1'b0,
        WAIT_RD = 1'b1
    } state_t;

    state_t state, state_n;

    logic             last_grant, last_grant_n;   // 0 = m0, 1 = m1
    logic             owner, owner_n;             // requester of in-flight read
    logic [CNT_W-1:0] tmo_cnt, tmo_cnt_n;

    logic        h_wr_en_n, h_rd_en_n;
    logic [15:0] h_addr_n;
    logic [31:0] h_wdata_n;
    logic [31:0] m0_readdata_n, m1_readdata_n;
    logic        m0_readdatavalid_n, m1_readdatavalid_n;
    logic [1:0]  grant_n;
    logic [7:0]  err_cnt_n;

    // Arbitration: m1 wins only when it alone is pending or it is its turn.
    logic                  pend0, pend1, sel, accept;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [31:0]           sel_wdata;
    logic                  sel_write;

    assign pend0  = m0_read | m0_write;
    assign pend1  = m1_read | m1_write;
    assign sel    = (pend0 && pend1) ? ~last_grant : pend1;
    assign accept = (state == IDLE) && !rst && (pend0 || pend1);

    assign sel_addr  = sel ? m1_address   : m0_address;
    assign sel_wdata = sel ? m1_writedata : m0_writedata;
    assign sel_write = sel ? m1_write     : m0_write;

    // Acceptance is signalled combinationally in the accept cycle.
    assign m0_waitrequest = !(accept && !sel);
    assign m1_waitrequest = !(accept &&  sel);

    assign busy = (state == WAIT_RD);

    // Next-state and next-output logic.
    always_comb begin
        state_n            = state;
        last_grant_n       = last_grant;
        owner_n            = owner;
        tmo_cnt_n          = tmo_cnt;
        h_wr_en_n          = 1'b0;
        h_rd_en_n          = 1'b0;
        h_addr_n           = h_addr;
        h_wdata_n          = h_wdata;
        m0_readdata_n      = m0_readdata;
        m1_readdata_n      = m1_readdata;
        m0_readdatavalid_n = 1'b0;
        m1_readdatavalid_n = 1'b0;
        grant_n            = grant;
        err_cnt_n          = err_cnt;

        case (state)
            IDLE: begin
                if (accept) begin
                    h_addr_n     = 16'(sel_addr);
                    h_wdata_n    = sel_wdata;
                    grant_n      = sel ? 2'b10 : 2'b01;
                    last_grant_n = sel;
                    owner_n      = sel;
                    // Write takes priority when read and write are both high.
                    if (sel_write) begin
                        h_wr_en_n = 1'b1;
                    end else begin
                        h_rd_en_n = 1'b1;
                        tmo_cnt_n = '0;
                        state_n   = WAIT_RD;
                    end
                end
            end

            WAIT_RD: begin
                if (h_rvalid || (tmo_cnt + CNT_W'(1) == TMO_LIMIT)) begin
                    state_n = IDLE;
                    if (owner) begin
                        m1_readdata_n      = h_rvalid ? h_rdata : TMO_DATA;
                        m1_readdatavalid_n = 1'b1;
                    end else begin
                        m0_readdata_n      = h_rvalid ? h_rdata : TMO_DATA;
                        m0_readdatavalid_n = 1'b1;
                    end
                    if (!h_rvalid && (err_cnt != 8'hFF)) begin
                        err_cnt_n = err_cnt + 8'd1;
                    end
                end else begin
                    tmo_cnt_n = tmo_cnt + CNT_W'(1);
                end
            end

            default: state_n = IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            last_grant       <= 1'b1;
            owner            <= 1'b0;
            tmo_cnt          <= '0;
            h_wr_en          <= 1'b0;
            h_rd_en          <= 1'b0;
            h_addr           <= '0;
            h_wdata          <= '0;
            m0_readdata      <= '0;
            m1_readdata      <= '0;
            m0_readdatavalid <= 1'b0;
            m1_readdatavalid <= 1'b0;
            grant            <= 2'b00;
            err_cnt          <= '0;
        end else begin
            state            <= state_n;
            last_grant       <= last_grant_n;
            owner            <= owner_n;
            tmo_cnt          <= tmo_cnt_n;
            h_wr_en          <= h_wr_en_n;
            h_rd_en          <= h_rd_en_n;
            h_addr           <= h_addr_n;
            h_wdata          <= h_wdata_n;
            m0_readdata      <= m0_readdata_n;
            m1_readdata      <= m1_readdata_n;
            m0_readdatavalid <= m0_readdatavalid_n;
            m1_readdatavalid <= m1_readdatavalid_n;
            grant            <= grant_n;
            err_cnt          <= err_cnt_n;
        end
    end

endmodule

// File: tb/tb_dsa_host_arbiter.sv
// Directed testbench for dsa_host_arbiter (RD_TIMEOUT = 8). Inputs change on
// the falling edge; outputs are sampled 1ns later, before the next rising edge.
module tb_dsa_host_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] m0_address, m1_address;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [31:0] m0_writedata, m1_writedata;
    logic        m0_waitrequest, m1_waitrequest;
    logic [31:0] m0_readdata, m1_readdata;
    logic        m0_readdatavalid, m1_readdatavalid;
    logic        h_wr_en, h_rd_en;
    logic [15:0] h_addr;
    logic [31:0] h_wdata, h_rdata;
    logic        h_rvalid;
    logic [1:0]  grant;
    logic        busy;
    logic [7:0]  err_cnt;

    int errors = 0;
    int checks = 0;

    dsa_host_arbiter #(.ADDR_WIDTH(16), .RD_TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
        .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
        .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
        .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
        .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
        .h_wr_en(h_wr_en), .h_rd_en(h_rd_en), .h_addr(h_addr),
        .h_wdata(h_wdata), .h_rdata(h_rdata), .h_rvalid(h_rvalid),
        .grant(grant), .busy(busy), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance to the next falling edge.
    task automatic next_cycle();
        @(negedge clk);
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        next_cycle();
        next_cycle();
        rst = 1'b0;
        next_cycle();
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        m0_address = '0; m1_address = '0; m0_writedata = '0; m1_writedata = '0;
        h_rdata = '0; h_rvalid = 1'b0;

        // Reset values; waitrequest stays high while rst is asserted.
        m0_write = 1'b1;
        #2;
        check("rst_wait0", 32'(m0_waitrequest), 32'd1);
        check("rst_wait1", 32'(m1_waitrequest), 32'd1);
        check("rst_wr_en", 32'(h_wr_en), 32'd0);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_errcnt", 32'(err_cnt), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        m0_write = 1'b0;
        next_cycle();
        rst = 1'b0;
        next_cycle();

        // Single m0 write.
        m0_write = 1'b1; m0_address = 16'h0010; m0_writedata = 32'h1234_5678;
        settle();
        check("wr_wait0", 32'(m0_waitrequest), 32'd0);
        check("wr_wait1", 32'(m1_waitrequest), 32'd1);
        next_cycle();
        idle_inputs();
        settle();
        check("wr_en", 32'(h_wr_en), 32'd1);
        check("wr_addr", 32'(h_addr), 32'h0010);
        check("wr_data", h_wdata, 32'h1234_5678);
        check("wr_grant", 32'(grant), 32'b01);
        next_cycle();
        check("wr_en_once", 32'(h_wr_en), 32'd0);

        // Both requesters write continuously from reset: m0, m1, m0, m1.
        do_reset();
        m0_write = 1'b1; m0_address = 16'h0001; m0_writedata = 32'hAAAA_0000;
        m1_write = 1'b1; m1_address = 16'h0002; m1_writedata = 32'hBBBB_0000;
        for (int i = 0; i < 4; i++) begin
            settle();
            check("rr_wait0", 32'(m0_waitrequest), (i % 2 == 0) ? 32'd0 : 32'd1);
            check("rr_wait1", 32'(m1_waitrequest), (i % 2 == 0) ? 32'd1 : 32'd0);
            if (i > 0) begin
                check("rr_wr_en", 32'(h_wr_en), 32'd1);
                check("rr_grant", 32'(grant), (i % 2 == 1) ? 32'b01 : 32'b10);
                check("rr_wdata", h_wdata, (i % 2 == 1) ? 32'hAAAA_0000 : 32'hBBBB_0000);
            end
            next_cycle();
        end
        idle_inputs();
        settle();
        check("rr_wr_en4", 32'(h_wr_en), 32'd1);
        check("rr_grant4", 32'(grant), 32'b10);
        next_cycle();
        check("rr_wr_en_end", 32'(h_wr_en), 32'd0);

        // m1 read with 3-cycle host latency; m0 write stalls until the response.
        m1_read = 1'b1; m1_address = 16'h0004;
        settle();
        check("rd_wait1", 32'(m1_waitrequest), 32'd0);
        next_cycle();
        idle_inputs();
        m0_write = 1'b1; m0_address = 16'h0030; m0_writedata = 32'h0000_0055;
        settle();
        check("rd_en", 32'(h_rd_en), 32'd1);
        check("rd_addr", 32'(h_addr), 32'h0004);
        check("rd_busy", 32'(busy), 32'd1);
        check("rd_grant", 32'(grant), 32'b10);
        check("rd_stall0", 32'(m0_waitrequest), 32'd1);
        next_cycle();
        check("rd_en_once", 32'(h_rd_en), 32'd0);
        check("rd_stall1", 32'(m0_waitrequest), 32'd1);
        next_cycle();
        check("rd_stall2", 32'(m0_waitrequest), 32'd1);
        next_cycle();
        h_rvalid = 1'b1; h_rdata = 32'hCAFE_0001;
        settle();
        check("rd_stall3", 32'(m0_waitrequest), 32'd1);
        check("rd_rdv_early", 32'(m1_readdatavalid), 32'd0);
        next_cycle();
        h_rvalid = 1'b0;
        settle();
        check("rd_rdv", 32'(m1_readdatavalid), 32'd1);
        check("rd_data", m1_readdata, 32'hCAFE_0001);
        check("rd_rdv_m0", 32'(m0_readdatavalid), 32'd0);
        check("rd_busy_end", 32'(busy), 32'd0);
        check("rd_accept0", 32'(m0_waitrequest), 32'd0);
        next_cycle();
        idle_inputs();
        settle();
        check("rd_rdv_once", 32'(m1_readdatavalid), 32'd0);
        check("rd_then_wr", 32'(h_wr_en), 32'd1);
        check("rd_then_addr", 32'(h_addr), 32'h0030);
        check("rd_then_grant", 32'(grant), 32'b01);
        next_cycle();

        // m0 read timeout after 8 WAIT_RD cycles; stray h_rvalid afterwards.
        m0_read = 1'b1; m0_address = 16'h0008;
        settle();
        check("to_wait0", 32'(m0_waitrequest), 32'd0);
        for (int k = 1; k <= 8; k++) begin
            next_cycle();
            idle_inputs();
            settle();
            check("to_no_rdv", 32'(m0_readdatavalid), 32'd0);
            check("to_busy", 32'(busy), 32'd1);
        end
        next_cycle();
        check("to_rdv", 32'(m0_readdatavalid), 32'd1);
        check("to_data", m0_readdata, 32'hDEAD_BEEF);
        check("to_errcnt", 32'(err_cnt), 32'd1);
        check("to_busy_end", 32'(busy), 32'd0);
        next_cycle();
        h_rvalid = 1'b1; h_rdata = 32'h1111_2222;
        next_cycle();
        h_rvalid = 1'b0;
        settle();
        check("stray_rdv0", 32'(m0_readdatavalid), 32'd0);
        check("stray_rdv1", 32'(m1_readdatavalid), 32'd0);
        check("stray_busy", 32'(busy), 32'd0);
        check("stray_data", m0_readdata, 32'hDEAD_BEEF);

        // Reset two cycles into a read, then a late h_rvalid.
        m0_read = 1'b1; m0_address = 16'h0040;
        next_cycle();
        idle_inputs();
        next_cycle();
        rst = 1'b1;
        settle();
        check("ar_busy", 32'(busy), 32'd0);
        check("ar_rd_en", 32'(h_rd_en), 32'd0);
        check("ar_addr", 32'(h_addr), 32'd0);
        check("ar_grant", 32'(grant), 32'd0);
        check("ar_errcnt", 32'(err_cnt), 32'd0);
        check("ar_rdata", m0_readdata, 32'd0);
        check("ar_wait0", 32'(m0_waitrequest), 32'd1);
        next_cycle();
        rst = 1'b0;
        h_rvalid = 1'b1; h_rdata = 32'h3333_4444;
        next_cycle();
        h_rvalid = 1'b0;
        settle();
        check("ar_no_rdv", 32'(m0_readdatavalid), 32'd0);
        check("ar_idle", 32'(busy), 32'd0);
        m0_write = 1'b1; m1_write = 1'b1;
        m0_address = 16'h0050; m1_address = 16'h0060;
        settle();
        check("ar_first0", 32'(m0_waitrequest), 32'd0);
        check("ar_first1", 32'(m1_waitrequest), 32'd1);
        next_cycle();
        idle_inputs();
        settle();
        check("ar_grant_m0", 32'(grant), 32'b01);
        next_cycle();

        // Read and write both high: treated as a write.
        m0_read = 1'b1; m0_write = 1'b1; m0_address = 16'h0020; m0_writedata = 32'h0000_0077;
        settle();
        check("rw_wait0", 32'(m0_waitrequest), 32'd0);
        next_cycle();
        idle_inputs();
        settle();
        check("rw_wr_en", 32'(h_wr_en), 32'd1);
        check("rw_rd_en", 32'(h_rd_en), 32'd0);
        check("rw_addr", 32'(h_addr), 32'h0020);
        check("rw_busy", 32'(busy), 32'd0);
        next_cycle();
        check("rw_wr_once", 32'(h_wr_en), 32'd0);
        check("rw_rd_none", 32'(h_rd_en), 32'd0);
        check("rw_busy2", 32'(busy), 32'd0);
        check("rw_no_rdv", 32'(m0_readdatavalid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
